// File: rtl/ps2_mouse_rx.sv
// ---------------------------------------------------------------------------
// ps2_mouse_rx
//
// Receiving end of the PS/2 mouse link. Deserialises 11-bit PS/2 frames
// (start, 8 data LSB first, odd parity, stop) from the asynchronous clock/data
// pair and assembles standard 3-byte movement packets into the 25-bit
// ps2_mouse word {toggle, Y, X, status} used by the mouse-to-joystick path.
// Every completed packet inverts bit 24, so consumers detect a new packet by
// watching that bit change rather than by sampling a strobe.
//
// Ports
//   clk_sys    in   1  system clock, everything runs in this domain
//   reset      in   1  synchronous, active-high reset
//   ps2_clk    in   1  PS/2 clock line (asynchronous, idle high)
//   ps2_dat    in   1  PS/2 data line (asynchronous, idle high)
//   ps2_mouse  out 25  [24] toggle, [23:16] Y, [15:8] X, [7:0] status
//   byte_stb   out  1  one-cycle pulse when a frame delivers a valid byte
//   rx_byte    out  8  last valid byte, held until the next byte_stb
//   err_stb    out  1  one-cycle pulse on parity/start/stop/sync/timeout error
//
// Output handshake: byte_stb and err_stb are plain single-cycle strobes with
// no ready/backpressure; a consumer that is not watching on that cycle misses
// the event. rx_byte is valid from the byte_stb cycle until the next one.
// ---------------------------------------------------------------------------
module ps2_mouse_rx #(
    parameter int FILTER      = 8,
    parameter int BIT_TIMEOUT = 60000,
    parameter int PKT_TIMEOUT = 1200000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [24:0] ps2_mouse,
    output logic        byte_stb,
    output logic [7:0]  rx_byte,
    output logic        err_stb
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int BW = $clog2(BIT_TIMEOUT + 1);
    localparam int PW = $clog2(PKT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Two-flop synchronizers. Reset to 1 so that reset itself never looks
    // like a falling clock edge on an idle bus.
    // -----------------------------------------------------------------------
    logic clk_s1;
    logic clk_s2;
    logic dat_s1;
    logic dat_s2;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Glitch filter on the clock line. The filtered level only follows the
    // synchronized level after FILTER consecutive samples that disagree with
    // it; any sample that agrees again restarts the count. The count never
    // exceeds FILTER-1, so it cannot wrap.
    // -----------------------------------------------------------------------
    logic [FW-1:0] filt_cnt;
    logic          clk_filt;
    logic          clk_filt_prev;
    logic          fall_evt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            filt_cnt      <= '0;
            clk_filt      <= 1'b1;
            clk_filt_prev <= 1'b1;
        end else begin
            clk_filt_prev <= clk_filt;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Falling edge of the filtered clock. Data is taken from the synchronized
    // (unfiltered) line at this point; PS/2 devices hold data stable across
    // the whole low phase, so the filter delay does not matter for data.
    assign fall_evt = clk_filt_prev & ~clk_filt;

    // -----------------------------------------------------------------------
    // Frame FSM and bit watchdog: state register
    // -----------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic [2:0]    bit_cnt_q;
    logic [2:0]    bit_cnt_d;
    logic          par_ok_q;
    logic          par_ok_d;
    logic [BW-1:0] wdog_q;
    logic [BW-1:0] wdog_d;

    // Frame-level events, valid in the cycle the deciding edge/expiry is seen;
    // the registered strobes follow one cycle later.
    logic          byte_ok_c;
    logic          frame_err_c;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_ok_q  <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_ok_q  <= par_ok_d;
            wdog_q    <= wdog_d;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM and bit watchdog: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        par_ok_d    = par_ok_q;
        wdog_d      = wdog_q;
        byte_ok_c   = 1'b0;
        frame_err_c = 1'b0;

        // Watchdog counts only inside a frame and restarts on every edge.
        // It saturates at BIT_TIMEOUT.
        if (state_q == S_IDLE || fall_evt) begin
            wdog_d = '0;
        end else if (wdog_q != BW'(BIT_TIMEOUT)) begin
            wdog_d = wdog_q + 1'b1;
        end

        if (fall_evt) begin
            // An edge always takes priority over a watchdog expiry that lands
            // on the same cycle.
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s2) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_c = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    // Odd parity: XOR of data plus parity bit must be 1.
                    par_ok_d = ^{shift_q, dat_s2};
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    if (dat_s2 && par_ok_q) begin
                        byte_ok_c = 1'b1;
                    end else begin
                        frame_err_c = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE && wdog_q == BW'(BIT_TIMEOUT)) begin
            frame_err_c = 1'b1;
            state_d     = S_IDLE;
            wdog_d      = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Packet assembly
    // -----------------------------------------------------------------------
    logic [1:0]    idx_q;
    logic [7:0]    byte0_q;
    logic [7:0]    byte1_q;
    logic [PW-1:0] pkt_cnt_q;
    logic          sync_err_c;
    logic          pkt_expire_c;

    // The first byte of a packet always has bit 3 set; anything else means we
    // are out of step with the mouse and must wait for a plausible header.
    assign sync_err_c   = byte_ok_c && (idx_q == 2'd0) && !shift_q[3];
    assign pkt_expire_c = (pkt_cnt_q == PW'(PKT_TIMEOUT));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            idx_q     <= '0;
            byte0_q   <= '0;
            byte1_q   <= '0;
            pkt_cnt_q <= '0;
            ps2_mouse <= '0;
            rx_byte   <= '0;
            byte_stb  <= 1'b0;
            err_stb   <= 1'b0;
        end else begin
            byte_stb <= byte_ok_c;
            err_stb  <= frame_err_c | sync_err_c;

            if (byte_ok_c) begin
                rx_byte <= shift_q;
            end

            // A byte arriving on the same cycle as the packet timeout is
            // placed using the index it arrived with, so byte handling is
            // checked before the timeout.
            if (byte_ok_c) begin
                unique case (idx_q)
                    2'd0: begin
                        if (shift_q[3]) begin
                            byte0_q <= shift_q;
                            idx_q   <= 2'd1;
                        end
                    end
                    2'd1: begin
                        byte1_q <= shift_q;
                        idx_q   <= 2'd2;
                    end
                    2'd2: begin
                        ps2_mouse <= {~ps2_mouse[24], shift_q, byte1_q, byte0_q};
                        idx_q     <= 2'd0;
                    end
                    default: begin
                        idx_q <= 2'd0;
                    end
                endcase
            end else if (frame_err_c || pkt_expire_c) begin
                // Partial packets are simply dropped; ps2_mouse keeps the
                // last complete packet.
                idx_q <= 2'd0;
            end

            // Inter-byte timer: runs only mid-packet, saturates at the limit.
            if (byte_ok_c || idx_q == 2'd0) begin
                pkt_cnt_q <= '0;
            end else if (!pkt_expire_c) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
module tb_ps2_mouse_rx;

  localparam int FILTER  = 4;
  localparam int BIT_TO  = 200;
  localparam int PKT_TO  = 1000;
  localparam int HALF    = 10;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [24:0] ps2_mouse;
  logic        byte_stb;
  logic [7:0]  rx_byte;
  logic        err_stb;

  always #5 clk_sys = ~clk_sys;

  ps2_mouse_rx #(
    .FILTER      (FILTER),
    .BIT_TIMEOUT (BIT_TO),
    .PKT_TIMEOUT (PKT_TO)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .ps2_mouse (ps2_mouse),
    .byte_stb  (byte_stb),
    .rx_byte   (rx_byte),
    .err_stb   (err_stb)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [24:0] exp_pkt_q[$];
  logic [24:0] prev_mouse = '0;
  logic        exp_tog = 1'b0;
  int          checks_total = 0;
  int          checks_pass  = 0;
  int          err_seen     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // monitor: pops expectations whenever the DUT presents a byte or a new packet
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_mouse = ps2_mouse;
    end else begin
      if (err_stb) err_seen++;
      if (byte_stb) begin
        if (exp_q.size() == 0) begin
          checks_total++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", rx_byte);
        end else begin
          check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
        end
      end
      if (ps2_mouse !== prev_mouse) begin
        if (exp_pkt_q.size() == 0) begin
          checks_total++;
          $display("FAIL unexpected_packet: got 0x%0h expected unchanged 0x%0h", ps2_mouse, prev_mouse);
        end else begin
          check("ps2_mouse", {7'h0, ps2_mouse}, {7'h0, exp_pkt_q.pop_front()});
        end
        prev_mouse = ps2_mouse;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // One PS/2 bit: data set with clock high, then clock low for HALF cycles.
  // With glitch set, a low pulse shorter than FILTER is put in the high phase.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(3);
      ps2_clk = 1'b0;
      wait_cyc(FILTER - 2);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 3 - (FILTER - 2));
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // glitch_pos: 0 start, 1..8 data, 9 parity, 10 stop, -1 none
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int glitch_pos);
    send_bit(1'b0, glitch_pos == 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch_pos == i + 1);
    send_bit((~^d) ^ bad_par, glitch_pos == 9);
    send_bit(1'b1, glitch_pos == 10);
    ps2_dat = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_good(input logic [7:0] d, input int glitch_pos);
    exp_q.push_back(d);
    send_frame(d, 1'b0, glitch_pos);
  endtask

  task automatic expect_packet(input logic [23:0] val);
    exp_tog = ~exp_tog;
    exp_pkt_q.push_back({exp_tog, val});
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [23:0] val);
    expect_packet(val);
    send_good(b0, -1);
    send_good(b1, -1);
    send_good(b2, -1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wait_cyc(3);
    check("reset_mouse", {7'h0, ps2_mouse}, 32'h0);
    check("reset_rx_byte", {24'h0, rx_byte}, 32'h0);
    check("reset_byte_stb", {31'h0, byte_stb}, 32'h0);
    check("reset_err_stb", {31'h0, err_stb}, 32'h0);
    reset = 1'b0;
    wait_cyc(20);

    // nominal packet
    send_packet(8'h09, 8'h05, 8'hFB, 24'hFB0509);
    wait_cyc(20);
    check("nominal_err_count", err_seen, 0);

    // bad parity on the third byte: error, packet dropped
    send_good(8'h09, -1);
    send_good(8'h05, -1);
    send_frame(8'hFB, 1'b1, -1);
    wait_cyc(20);
    check("parity_err_count", err_seen, 1);
    send_packet(8'h08, 8'h00, 8'h00, 24'h000008);
    wait_cyc(20);

    // sync loss: header without bit 3 is delivered as a byte but rejected
    send_good(8'h01, -1);
    wait_cyc(20);
    check("sync_err_count", err_seen, 2);
    send_packet(8'h08, 8'h10, 8'h20, 24'h201008);
    wait_cyc(20);

    // bit timeout: start + 4 data bits, then the clock stops
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    ps2_dat = 1'b1;
    wait_cyc(BIT_TO + 40);
    check("bit_timeout_err_count", err_seen, 3);
    send_packet(8'h08, 8'h7F, 8'h80, 24'h807F08);
    wait_cyc(20);
    check("after_timeout_err_count", err_seen, 3);

    // glitch rejection: idle 1-cycle pulse, then sub-FILTER pulses mid-frame
    ps2_clk = 1'b0;
    wait_cyc(1);
    ps2_clk = 1'b1;
    wait_cyc(30);
    expect_packet(24'h332218);
    send_good(8'h18, -1);
    send_good(8'h22, 4);
    send_good(8'h33, 10);
    wait_cyc(20);
    check("glitch_err_count", err_seen, 3);

    // packet timeout: two bytes, long gap, then a full packet
    send_good(8'h08, -1);
    send_good(8'h01, -1);
    wait_cyc(PKT_TO + 50);
    send_packet(8'h08, 8'h01, 8'h02, 24'h020108);
    wait_cyc(20);
    check("pkt_timeout_err_count", err_seen, 3);

    // reset mid-frame
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    reset = 1'b1;
    wait_cyc(1);
    check("midreset_mouse", {7'h0, ps2_mouse}, 32'h0);
    check("midreset_rx_byte", {24'h0, rx_byte}, 32'h0);
    check("midreset_byte_stb", {31'h0, byte_stb}, 32'h0);
    check("midreset_err_stb", {31'h0, err_stb}, 32'h0);
    wait_cyc(1);
    reset = 1'b0;
    ps2_dat = 1'b1;
    exp_tog = 1'b0;
    wait_cyc(40);
    send_packet(8'h08, 8'h0A, 8'h0B, 24'h0B0A08);
    wait_cyc(20);
    check("final_err_count", err_seen, 3);

    // drain, bounded
    for (int i = 0; i < 500 && (exp_q.size() != 0 || exp_pkt_q.size() != 0); i++)
      wait_cyc(1);
    check("byte_queue_empty", exp_q.size(), 0);
    check("pkt_queue_empty", exp_pkt_q.size(), 0);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
